// File: rtl/store_write_port_pkg.sv
// rtl/store_write_port_pkg.sv - shared store encodings, exception codes and memory map
package store_write_port_pkg;

    typedef enum logic [2:0] {
        ST_NONE = 3'b000,
        ST_SH   = 3'b001,
        ST_SB   = 3'b010,
        ST_SW   = 3'b011
    } store_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } wr_state_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] DM_HI      = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO     = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI     = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO     = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI     = 32'h0000_7F1B;
    localparam logic [31:0] IG_LO      = 32'h0000_7F20;
    localparam logic [31:0] IG_HI      = 32'h0000_7F23;
    // COUNT register occupies the last word of each timer block
    localparam logic [31:0] TC_CNT_OFS = 32'h0000_0008;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/store_write_port_if.sv
// rtl/store_write_port_if.sv - write bus toward DM and the peripheral bridge
interface store_write_port_if;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_ack
    );
endinterface

// File: rtl/store_write_port_lane_gen.sv
// rtl/store_write_port_lane_gen.sv - byte enables, lane replication and AdES detection
module store_lane_gen
    import store_write_port_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [4:0]  exc,
    output logic        op_valid
);

    logic in_dm;
    logic in_tc;
    logic in_ig;
    logic in_cnt;
    logic bad;

    // Decode the target region, then apply per-size alignment and width rules
    always_comb begin
        be       = 4'b0000;
        wdata    = 32'h0;
        exc      = EXC_NONE;
        op_valid = 1'b0;
        in_dm    = (a <= DM_HI);
        in_tc    = in_range(a, TC0_LO, TC0_HI) || in_range(a, TC1_LO, TC1_HI);
        in_ig    = in_range(a, IG_LO, IG_HI);
        in_cnt   = in_range(a, TC0_LO + TC_CNT_OFS, TC0_HI) ||
                   in_range(a, TC1_LO + TC_CNT_OFS, TC1_HI);
        bad      = !(in_dm || in_tc || in_ig) || in_cnt;
        case (op)
            ST_SW: begin
                op_valid = 1'b1;
                be       = 4'b1111;
                wdata    = wd;
                bad      = bad || (a[1:0] != 2'b00);
            end
            ST_SH: begin
                op_valid = 1'b1;
                be       = a[1] ? 4'b1100 : 4'b0011;
                wdata    = {wd[15:0], wd[15:0]};
                // timers only accept full-word writes
                bad      = bad || a[0] || in_tc;
            end
            ST_SB: begin
                op_valid = 1'b1;
                be       = 4'b0001 << a[1:0];
                wdata    = {4{wd[7:0]}};
                bad      = bad || in_tc;
            end
            default: begin
                op_valid = 1'b0;
            end
        endcase
        if (op_valid && bad) begin
            exc = EXC_ADES;
        end
    end

endmodule

// File: rtl/store_write_port.sv
// rtl/store_write_port.sv - MEM-stage store issue FSM with ack/timeout handshake
module store_write_port
    import store_write_port_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                st_valid,
    input  logic [2:0]          StoreOp,
    input  logic [31:0]         A,
    input  logic [31:0]         wd,
    input  logic                flush,
    store_write_port_if.master  bus,
    output logic                stall,
    output logic [4:0]          ExcStore,
    output logic                timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wr_state_e      state;
    wr_state_e      next_state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]     lg_be;
    logic [31:0]    lg_wdata;
    logic [4:0]     lg_exc;
    logic           lg_op_valid;
    logic           go;
    logic           do_accept;
    logic           do_ack;
    logic           do_timeout;

    store_lane_gen u_lane_gen (
        .op       (StoreOp),
        .a        (A),
        .wd       (wd),
        .be       (lg_be),
        .wdata    (lg_wdata),
        .exc      (lg_exc),
        .op_valid (lg_op_valid)
    );

    assign ExcStore = lg_exc;
    assign go       = st_valid && lg_op_valid && (lg_exc == EXC_NONE) && !flush;

    // Next-state and stall; ack wins over timeout in the last wait cycle
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        do_accept  = 1'b0;
        do_ack     = 1'b0;
        do_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    next_state = S_WAIT;
                    stall      = 1'b1;
                    do_accept  = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.bus_ack) begin
                    next_state = S_IDLE;
                    do_ack     = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = S_IDLE;
                    do_timeout = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request, latched write payload, wait counter and timeout pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.bus_req   <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_wdata <= 32'h0;
            bus.bus_be    <= 4'b0000;
            cnt           <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= do_timeout;
            if (do_accept) begin
                bus.bus_req   <= 1'b1;
                bus.bus_addr  <= {A[31:2], 2'b00};
                bus.bus_wdata <= lg_wdata;
                bus.bus_be    <= lg_be;
                cnt           <= '0;
            end else if (do_ack || do_timeout) begin
                bus.bus_req <= 1'b0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_write_port.sv
// tb/tb_store_write_port.sv - randomized and directed checks against a behavioural store model
module tb_store_write_port;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] wd = 32'h0;
    logic        stall;
    logic        timeout_err;
    logic [4:0]  exc;

    int n_chk = 0;
    int n_pass = 0;

    // behavioural model: at most one outstanding write and its age in wait cycles
    bit          m_req;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_be;
    int          m_age;
    bit          m_to;
    bit          g_go;
    bit          g_ack;
    logic [31:0] g_a;
    logic [31:0] g_wd;
    logic [2:0]  g_op;

    store_write_port_if bif ();

    store_write_port #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .StoreOp     (op),
        .A           (a),
        .wd          (wd),
        .flush       (flush),
        .bus         (bif.master),
        .stall       (stall),
        .ExcStore    (exc),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic int op_size(input logic [2:0] o);
        case (o)
            3'b001:  return 2;
            3'b010:  return 1;
            3'b011:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit inr(input logic [31:0] x, input logic [31:0] lo, input logic [31:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    function automatic logic [4:0] ref_exc(input logic [2:0] o, input logic [31:0] x);
        int sz;
        bit tc;
        bit bad;
        sz = op_size(o);
        if (sz == 0) return 5'd0;
        tc  = inr(x, 32'h7F00, 32'h7F0B) || inr(x, 32'h7F10, 32'h7F1B);
        bad = (x % 32'(sz)) != 0;
        if (tc && sz < 4) bad = 1;
        if (inr(x, 32'h7F08, 32'h7F0B) || inr(x, 32'h7F18, 32'h7F1B)) bad = 1;
        if (!(inr(x, 32'h0, 32'h2FFF) || tc || inr(x, 32'h7F20, 32'h7F23))) bad = 1;
        return bad ? 5'd5 : 5'd0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] o, input logic [31:0] x);
        int m;
        m = ((1 << op_size(o)) - 1) << int'(x[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_data(input logic [2:0] o, input logic [31:0] w);
        logic [31:0] d;
        int sz;
        sz = op_size(o);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % sz) +: 8];
        return d;
    endfunction

    task automatic drive(input bit v, input logic [2:0] o, input logic [31:0] ad,
                         input logic [31:0] d, input bit f, input bit ack);
        st_valid    = v;
        op          = o;
        a           = ad;
        wd          = d;
        flush       = f;
        bif.bus_ack = ack;
    endtask

    // let inputs settle, compare every output with the model
    task automatic settle();
        logic [4:0] e;
        bit s;
        #2;
        e     = ref_exc(op, a);
        g_go  = st_valid && op_size(op) != 0 && e == 5'd0 && !flush;
        g_ack = bif.bus_ack;
        g_a   = a;
        g_wd  = wd;
        g_op  = op;
        s     = m_req ? (!g_ack && m_age != TIMEOUT - 1) : g_go;
        check("exc", 32'(exc), 32'(e));
        check("stall", 32'(stall), 32'(s));
        check("req", 32'(bif.bus_req), 32'(m_req));
        check("terr", 32'(timeout_err), 32'(m_to));
        if (m_req) begin
            check("addr", bif.bus_addr, m_addr);
            check("wdata", bif.bus_wdata, m_data);
            check("be", 32'(bif.bus_be), 32'(m_be));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        m_to = m_req && !g_ack && m_age == TIMEOUT - 1;
        if (!m_req) begin
            if (g_go) begin
                m_req  = 1;
                m_age  = 0;
                m_addr = g_a & 32'hFFFF_FFFC;
                m_data = ref_data(g_op, g_wd);
                m_be   = ref_be(g_op, g_a);
            end
        end else if (g_ack || m_age == TIMEOUT - 1) begin
            m_req = 0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic model_reset();
        m_req = 0; m_age = 0; m_to = 0;
        m_addr = 0; m_data = 0; m_be = 0;
    endtask

    logic [2:0]  f_op [5] = '{3'b011, 3'b001, 3'b010, 3'b011, 3'b011};
    logic [31:0] f_a  [5] = '{32'h6, 32'h1, 32'h7F04, 32'h7F08, 32'h3000};

    initial begin
        int req_cnt;
        int to_cnt;
        int st_cnt;
        int mode;
        model_reset();
        bif.bus_ack = 1'b0;
        #2;
        check("rst_req", 32'(bif.bus_req), 32'h0);
        check("rst_addr", bif.bus_addr, 32'h0);
        check("rst_be", 32'(bif.bus_be), 32'h0);
        check("rst_terr", 32'(timeout_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // sb to 0x1003, ack in the second wait cycle
        st_cnt = 0;
        drive(1, 3'b010, 32'h1003, 32'h1234_56AB, 0, 0);
        settle(); st_cnt += int'(stall); advance();
        drive(0, 3'b000, 32'h0, 32'h0, 0, 0);
        settle(); st_cnt += int'(stall);
        check("sb_be", 32'(bif.bus_be), 32'h8);
        check("sb_wdata", bif.bus_wdata, 32'hABAB_ABAB);
        check("sb_addr", bif.bus_addr, 32'h1000);
        advance();
        bif.bus_ack = 1'b1;
        settle(); st_cnt += int'(stall); advance();
        check("sb_stall_cycles", 32'(st_cnt), 32'd2);
        bif.bus_ack = 1'b0;

        // sh then back-to-back sw
        drive(1, 3'b001, 32'h2, 32'h0000_BEEF, 0, 0);
        cyc();
        drive(1, 3'b011, 32'h0, 32'hCAFE_F00D, 0, 1);
        settle();
        check("sh_be", 32'(bif.bus_be), 32'hC);
        check("sh_wdata", bif.bus_wdata, 32'hBEEF_BEEF);
        advance();
        bif.bus_ack = 1'b0;
        settle();
        check("b2b_stall", 32'(stall), 32'h1);
        advance();
        drive(0, 3'b000, 32'h0, 32'h0, 0, 1);
        settle();
        check("sw_be", 32'(bif.bus_be), 32'hF);
        advance();
        bif.bus_ack = 1'b0;

        // address faults
        for (int i = 0; i < 5; i++) begin
            drive(1, f_op[i], f_a[i], 32'h5555_AAAA, 0, 0);
            settle();
            check("fault_exc", 32'(exc), 32'd5);
            check("fault_stall", 32'(stall), 32'h0);
            advance();
            check("fault_req", 32'(bif.bus_req), 32'h0);
        end

        // timeout on the interrupt generator
        req_cnt = 0; to_cnt = 0;
        drive(1, 3'b011, 32'h7F20, 32'h1, 0, 0);
        cyc();
        drive(0, 3'b000, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            settle();
            req_cnt += int'(bif.bus_req);
            to_cnt  += int'(timeout_err);
            advance();
        end
        check("to_req_cycles", 32'(req_cnt), 32'd16);
        check("to_pulses", 32'(to_cnt), 32'd1);

        // flush in IDLE blocks, flush in WAIT does not
        drive(1, 3'b011, 32'h100, 32'h77, 1, 0);
        cyc();
        check("flush_idle_req", 32'(bif.bus_req), 32'h0);
        drive(1, 3'b011, 32'h104, 32'h88, 0, 0);
        cyc();
        drive(0, 3'b000, 32'h0, 32'h0, 1, 0);
        repeat (3) cyc();
        check("flush_wait_req", 32'(bif.bus_req), 32'h1);
        bif.bus_ack = 1'b1;
        cyc();
        drive(0, 3'b000, 32'h0, 32'h0, 0, 0);
        cyc();

        // async reset while waiting
        drive(1, 3'b011, 32'h200, 32'h99, 0, 0);
        cyc();
        drive(0, 3'b000, 32'h0, 32'h0, 0, 0);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req", 32'(bif.bus_req), 32'h0);
        check("arst_stall", 32'(stall), 32'h0);
        check("arst_addr", bif.bus_addr, 32'h0);
        check("arst_wdata", bif.bus_wdata, 32'h0);
        check("arst_be", 32'(bif.bus_be), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized traffic
        mode = 1;
        for (int i = 0; i < 800; i++) begin
            logic [31:0] ad;
            if (!m_req) mode = int'($urandom % 4);
            case ($urandom % 5)
                0: ad = $urandom % 32'h3000;
                1: ad = 32'h7F00 + ($urandom % 48);
                2: ad = 32'h2FFC + ($urandom % 8);
                3: ad = $urandom;
                default: ad = 32'h7F20 + ($urandom % 4);
            endcase
            if ($urandom % 2 == 0) ad[1:0] = 2'b00;
            drive(($urandom % 4) != 0, 3'($urandom % 8), ad, $urandom,
                  ($urandom % 8) == 0,
                  (mode == 0) ? 1'b0 : (($urandom % mode) == 0));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
